rom_dl_writer: RTL and testbench



---
 rtl/rom_dl_writer_pkg.sv | 30 +++
 rtl/rom_dl_writer_if.sv | 24 ++
 rtl/rom_dl_writer_fifo.sv | 56 +++++
 rtl/rom_dl_writer.sv | 142 ++++++++++++++
 tb/tb_rom_dl_writer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_dl_writer_pkg.sv
// rom_dl_writer shared types: loader FSM states,
// FIFO beat layout and the default image size.
package rom_dl_writer_pkg;

  localparam int AW = 25;

  // Program + sprite + tile + CLUT regions, back to back
  localparam logic [AW-1:0] IMG_SIZE_DEF = 25'h2C100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } dl_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } dl_beat_t;

  function automatic logic [15:0] csum_add(
    input logic [15:0] s,
    input logic [7:0]  b
  );
    return s + {8'h00, b};
  endfunction

endpackage

// File: rtl/rom_dl_writer_if.sv
// Byte stream from the HPS loader into the
// download writer (valid/ready, last-qualified).
interface rom_dl_writer_if;

  logic       S_VALID;
  logic [7:0] S_DATA;
  logic       S_LAST;
  logic       S_READY;

  modport master (
    output S_VALID,
    output S_DATA,
    output S_LAST,
    input  S_READY
  );

  modport slave (
    input  S_VALID,
    input  S_DATA,
    input  S_LAST,
    output S_READY
  );

endinterface

// File: rtl/rom_dl_writer_fifo.sv
// dl_fifo: small synchronous FIFO between the
// loader stream and the paced ROM write engine.
module dl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push)
        wp <= wp + 1'b1;
      if (do_pop)
        rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp] <= wdata;
  end

endmodule

// File: rtl/rom_dl_writer.sv
// rom_dl_writer: buffers the HPS ROM image stream and
// emits paced ROMEN writes, length check and checksum.
module rom_dl_writer
  import rom_dl_writer_pkg::*;
#(
  parameter logic [24:0] IMG_SIZE   = IMG_SIZE_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PACE       = 2
) (
  input  logic             ROMCL,
  input  logic             RESET,
  input  logic             DL_START,
  rom_dl_writer_if.slave   s,
  output logic [24:0]      ROMAD,
  output logic [7:0]       ROMDT,
  output logic             ROMEN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [15:0]      CSUM,
  output logic             HOLD
);

  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;

  dl_state_t     state;
  dl_state_t     state_nx;
  dl_beat_t      fifo_in;
  dl_beat_t      fifo_out;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [24:0]   acc_cnt;
  logic [24:0]   wr_cnt;
  logic          ovf;
  logic          seen_last;
  logic          drained;
  logic          good;
  logic [PW-1:0] pace_cnt;

  assign s.S_READY = (state == ST_LOAD) & ~full
                   & ~DL_START;
  assign accept    = s.S_VALID & s.S_READY;

  // Bytes past the image size are swallowed, not stored
  assign push      = accept & (acc_cnt != IMG_SIZE);
  assign pop       = ~empty & (pace_cnt == '0)
                   & ~DL_START;

  assign fifo_in.last = s.S_LAST;
  assign fifo_in.data = s.S_DATA;

  dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk   (ROMCL),
    .rst   (RESET),
    .clr   (DL_START),
    .push  (push),
    .wdata (fifo_in),
    .pop   (pop),
    .rdata (fifo_out),
    .full  (full),
    .empty (empty)
  );

  // Checksum is final only once the last strobe retired
  assign drained = empty & ~ROMEN;
  assign good    = (wr_cnt == IMG_SIZE) & ~ovf
                 & seen_last;

  always_ff @(posedge ROMCL) begin
    if (RESET)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (DL_START) begin
      state_nx = ST_LOAD;
    end else begin
      unique case (state)
        ST_LOAD:
          if (accept && s.S_LAST)
            state_nx = ST_DRAIN;
        ST_DRAIN:
          if (drained)
            state_nx = good ? ST_DONE : ST_ERROR;
        default:
          state_nx = state;
      endcase
    end
  end

  always_ff @(posedge ROMCL) begin
    if (RESET || DL_START) begin
      ROMAD     <= '0;
      ROMDT     <= '0;
      ROMEN     <= 1'b0;
      CSUM      <= '0;
      pace_cnt  <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      ovf       <= 1'b0;
      seen_last <= 1'b0;
    end else begin
      ROMEN <= pop;
      ROMAD <= ROMAD + {24'd0, ROMEN};
      if (ROMEN)
        CSUM <= csum_add(CSUM, ROMDT);
      if (pop) begin
        ROMDT    <= fifo_out.data;
        pace_cnt <= PW'(PACE - 1);
        wr_cnt   <= wr_cnt + 1'b1;
        if (fifo_out.last)
          seen_last <= 1'b1;
      end else if (pace_cnt != '0) begin
        pace_cnt <= pace_cnt - 1'b1;
      end
      if (accept) begin
        if (acc_cnt == IMG_SIZE)
          ovf <= 1'b1;
        else
          acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  assign BUSY = (state == ST_LOAD)
              | (state == ST_DRAIN);
  assign DONE = (state == ST_DONE);
  assign ERR  = (state == ST_ERROR);

  // CPU runs only on a verified image
  assign HOLD = ~DONE;

endmodule

// File: tb/tb_rom_dl_writer.sv
// Directed bench for rom_dl_writer with a reduced
// image size so full downloads stay short.
module tb_rom_dl_writer;

  localparam logic [24:0] IMG = 25'h140;
  localparam int          N   = 320;

  logic        ROMCL = 1'b0;
  logic        RESET = 1'b1;
  logic        DL_START = 1'b0;
  logic [24:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        ROMEN;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] CSUM;
  logic        HOLD;

  rom_dl_writer_if s ();

  rom_dl_writer #(
    .IMG_SIZE   (IMG),
    .FIFO_DEPTH (4),
    .PACE       (2)
  ) dut (
    .ROMCL    (ROMCL),
    .RESET    (RESET),
    .DL_START (DL_START),
    .s        (s),
    .ROMAD    (ROMAD),
    .ROMDT    (ROMDT),
    .ROMEN    (ROMEN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .CSUM     (CSUM),
    .HOLD     (HOLD)
  );

  always #5 ROMCL = ~ROMCL;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_ad[$];
  int wr_dt[$];
  int wr_cy[$];
  int acc_cy[$];

  always @(posedge ROMCL) begin
    #2;
    cyc++;
    if (ROMEN === 1'b1) begin
      wr_ad.push_back(int'(ROMAD));
      wr_dt.push_back(int'(ROMDT));
      wr_cy.push_back(cyc);
    end
  end

  function automatic int seq_errs();
    int e = 0;
    for (int i = 0; i < wr_ad.size(); i++)
      if (wr_ad[i] != i || wr_dt[i] != (i & 255))
        e++;
    return e;
  endfunction

  function automatic int model_sum(input int n);
    int sm = 0;
    for (int i = 0; i < n; i++)
      sm = (sm + (i & 255)) & 16'hFFFF;
    return sm;
  endfunction

  task automatic start_dl();
    wr_ad.delete();
    wr_dt.delete();
    wr_cy.delete();
    acc_cy.delete();
    @(negedge ROMCL);
    DL_START = 1'b1;
    @(negedge ROMCL);
    DL_START = 1'b0;
  endtask

  task automatic send(input int n, input bit lst,
                      output bit to);
    int w;
    to = 1'b0;
    for (int i = 0; i < n && !to; i++) begin
      @(negedge ROMCL);
      s.S_VALID = 1'b1;
      s.S_DATA  = i[7:0];
      s.S_LAST  = lst && (i == n - 1);
      #1;
      w = 0;
      while (!s.S_READY && !to) begin
        w++;
        if (w > 64) to = 1'b1;
        else begin
          @(negedge ROMCL);
          #1;
        end
      end
      if (!to) acc_cy.push_back(cyc);
    end
    @(negedge ROMCL);
    s.S_VALID = 1'b0;
    s.S_LAST  = 1'b0;
    total++;
    if (to) begin
      bad++;
      $display("FAIL send_ready: S_READY got 0 want 1");
    end
  endtask

  task automatic wait_end(output bit hok);
    bit prev = 1'b1;
    int n = 0;
    hok = 1'b0;
    forever begin
      @(negedge ROMCL);
      #1;
      if (DONE || ERR) begin
        hok = DONE ? (prev && !HOLD) : HOLD;
        break;
      end
      prev = HOLD;
      n++;
      if (n > 2000) begin
        total++;
        bad++;
        $display("FAIL wait_end: no DONE/ERR in %0d", n);
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ROMCL);
    #1;
    total++;
    if ({ROMEN, BUSY, DONE, ERR, HOLD} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00001",
               {ROMEN, BUSY, DONE, ERR, HOLD});
    end
    total++;
    if (ROMAD !== 25'd0 || ROMDT !== 8'd0) begin
      bad++;
      $display("FAIL reset_bus: got %h/%h want 0/0",
               ROMAD, ROMDT);
    end
    total++;
    if (CSUM !== 16'd0) begin
      bad++;
      $display("FAIL reset_csum: got %h want 0", CSUM);
    end
    RESET = 1'b0;
    s.S_VALID = 1'b1;
    @(negedge ROMCL);
    #1;
    total++;
    if (s.S_READY !== 1'b0 || HOLD !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: got %b%b want 01",
               s.S_READY, HOLD);
    end
    s.S_VALID = 1'b0;
  endtask

  task automatic test_full_image();
    bit to, hok;
    int gaps = 0;
    start_dl();
    #1;
    total++;
    if (BUSY !== 1'b1 || HOLD !== 1'b1) begin
      bad++;
      $display("FAIL full_busy: got %b%b want 11",
               BUSY, HOLD);
    end
    send(N, 1'b1, to);
    wait_end(hok);
    total++;
    if (wr_ad.size() != N) begin
      bad++;
      $display("FAIL full_count: got %0d want %0d",
               wr_ad.size(), N);
    end
    total++;
    if (seq_errs() != 0) begin
      bad++;
      $display("FAIL full_seq: got %0d errs want 0",
               seq_errs());
    end
    for (int i = 1; i < wr_cy.size(); i++)
      if (wr_cy[i] - wr_cy[i-1] != 2) gaps++;
    total++;
    if (gaps != 0) begin
      bad++;
      $display("FAIL full_pace: got %0d bad gaps want 0",
               gaps);
    end
    total++;
    if (wr_cy.size() == 0 || acc_cy.size() == 0 ||
        wr_cy[0] - acc_cy[0] != 2) begin
      bad++;
      $display("FAIL full_latency: got %0d want 2",
               (wr_cy.size() > 0 && acc_cy.size() > 0)
               ? wr_cy[0] - acc_cy[0] : -1);
    end
    total++;
    if ({DONE, ERR, HOLD} !== 3'b100) begin
      bad++;
      $display("FAIL full_status: got %b want 100",
               {DONE, ERR, HOLD});
    end
    total++;
    if (!hok) begin
      bad++;
      $display("FAIL full_hold_edge: got 0 want 1");
    end
    total++;
    if (int'(CSUM) != model_sum(N)) begin
      bad++;
      $display("FAIL full_csum: got %h want %h",
               CSUM, model_sum(N));
    end
  endtask

  task automatic test_backpressure();
    bit to, hok;
    int odd = 0;
    start_dl();
    send(N, 1'b1, to);
    wait_end(hok);
    for (int i = 12; i < acc_cy.size(); i++)
      if (acc_cy[i] - acc_cy[i-1] != 2) odd++;
    total++;
    if (odd != 0 || acc_cy.size() != N) begin
      bad++;
      $display("FAIL bp_ready: got %0d odd/%0d want 0/%0d",
               odd, acc_cy.size(), N);
    end
    total++;
    if (wr_ad.size() != N || seq_errs() != 0) begin
      bad++;
      $display("FAIL bp_data: got %0d/%0d want %0d/0",
               wr_ad.size(), seq_errs(), N);
    end
    total++;
    if (DONE !== 1'b1) begin
      bad++;
      $display("FAIL bp_done: got %b want 1", DONE);
    end
  endtask

  task automatic test_short();
    bit to, hok;
    start_dl();
    send(256, 1'b1, to);
    wait_end(hok);
    total++;
    if ({DONE, ERR, HOLD} !== 3'b011 || !hok) begin
      bad++;
      $display("FAIL short_status: got %b want 011",
               {DONE, ERR, HOLD});
    end
    total++;
    if (wr_ad.size() != 256 || seq_errs() != 0) begin
      bad++;
      $display("FAIL short_count: got %0d want 256",
               wr_ad.size());
    end
    total++;
    if (CSUM !== 16'h7F80) begin
      bad++;
      $display("FAIL short_csum: got %h want 7f80", CSUM);
    end
  endtask

  task automatic test_overflow();
    bit to, hok;
    start_dl();
    send(N + 3, 1'b1, to);
    wait_end(hok);
    total++;
    if (wr_ad.size() != N || seq_errs() != 0) begin
      bad++;
      $display("FAIL ovf_count: got %0d want %0d",
               wr_ad.size(), N);
    end
    total++;
    if ({DONE, ERR, HOLD} !== 3'b011) begin
      bad++;
      $display("FAIL ovf_status: got %b want 011",
               {DONE, ERR, HOLD});
    end
    total++;
    if (int'(CSUM) != model_sum(N)) begin
      bad++;
      $display("FAIL ovf_csum: got %h want %h",
               CSUM, model_sum(N));
    end
  endtask

  task automatic test_restart();
    bit to, hok;
    start_dl();
    send(50, 1'b0, to);
    s.S_VALID = 1'b1;
    s.S_DATA  = 8'hAA;
    DL_START  = 1'b1;
    #1;
    total++;
    if (s.S_READY !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready: got %b want 0",
               s.S_READY);
    end
    @(negedge ROMCL);
    DL_START  = 1'b0;
    s.S_VALID = 1'b0;
    #1;
    total++;
    if (ROMAD !== 25'd0 || CSUM !== 16'd0 ||
        ROMEN !== 1'b0 || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL rst_clear: got %h/%h/%b%b want 0/0/01",
               ROMAD, CSUM, ROMEN, BUSY);
    end
    wr_ad.delete();
    wr_dt.delete();
    wr_cy.delete();
    acc_cy.delete();
    send(N, 1'b1, to);
    wait_end(hok);
    total++;
    if (wr_ad.size() != N || seq_errs() != 0 ||
        DONE !== 1'b1) begin
      bad++;
      $display("FAIL rst_image: got %0d/%b want %0d/1",
               wr_ad.size(), DONE, N);
    end
    total++;
    if (int'(CSUM) != model_sum(N)) begin
      bad++;
      $display("FAIL rst_csum: got %h want %h",
               CSUM, model_sum(N));
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int rdy = 0;
    start_dl();
    send(20, 1'b0, to);
    s.S_VALID = 1'b1;
    s.S_DATA  = 8'h5A;
    RESET     = 1'b1;
    @(negedge ROMCL);
    #1;
    total++;
    if ({ROMEN, s.S_READY, HOLD, BUSY, DONE}
        !== 5'b00100) begin
      bad++;
      $display("FAIL mid_reset: got %b want 00100",
               {ROMEN, s.S_READY, HOLD, BUSY, DONE});
    end
    RESET = 1'b0;
    wr_ad.delete();
    wr_dt.delete();
    wr_cy.delete();
    repeat (20) begin
      @(negedge ROMCL);
      #1;
      if (s.S_READY) rdy++;
    end
    s.S_VALID = 1'b0;
    total++;
    if (wr_ad.size() != 0 || rdy != 0) begin
      bad++;
      $display("FAIL mid_quiet: got %0d wr %0d rdy want 0",
               wr_ad.size(), rdy);
    end
    total++;
    if (CSUM !== 16'd0 || ROMAD !== 25'd0) begin
      bad++;
      $display("FAIL mid_regs: got %h/%h want 0/0",
               CSUM, ROMAD);
    end
  endtask

  initial begin
    s.S_VALID = 1'b0;
    s.S_DATA  = 8'h00;
    s.S_LAST  = 1'b0;
    test_reset();
    test_full_image();
    test_backpressure();
    test_short();
    test_overflow();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
